mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences a single-ported unified instruction/data memory shared by the fetch stage (IF) and the load/store stage (DM).
- Grants one requester per transaction and drives the shared memory command port through internal select muxes.
- Tracks the in-flight transaction and routes the fixed-latency read response back to the owning requester.
- Requesters stall while `req` is high and `gnt` is low.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits. Must be a multiple of 8.
- MEM_LAT, 2, fixed memory latency in cycles, from command to `mem_rdata` valid. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; `if_rdata` valid.
- if_rdata  out  DW  fetched word.
- dm_req  in  1  data request; held with its fields stable until `dm_gnt`.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  DW  store data.
- dm_be  in  DW/8  store byte enables.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  one-cycle pulse; load data valid, or store completion ack.
- dm_rdata  out  DW  load data. Equals `mem_rdata` when `dm_rvalid`=1 and `dm_we`=0.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables. Forced to all-ones on fetch.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after `mem_en`.
- busy  out  1  transaction in flight.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - clk and rst are the clock and reset; rst is synchronous, active-high.
- Reset values:
  - State = IDLE, counter = 0, owner = DM, last_gnt = IF.
  - All outputs 0: `if_gnt`, `dm_gnt`, `if_rvalid`, `dm_rvalid`, `mem_en`, `mem_we`, `busy`, data/address buses.
- State machine: IDLE and BUSY.
- Grant eligibility: a grant is allowed in a cycle when state = IDLE, or when state = BUSY and counter = MEM_LAT-1 (the response cycle).
- Grant decision (combinational, same cycle as `req`):
  - Default arbitration: DM has fixed priority over IF.
  - Exactly one `gnt` is high in a granting cycle.
  - `mem_*` is driven from the granted requester's fields in that cycle, with `mem_en`=1.
  - `mem_en`=0 in every non-granting cycle. Inactive `mem_*` buses are 0.
- On grant (registered):
  - owner ← granted requester; we_q ← `dm_we` (0 for IF); last_gnt ← granted requester.
  - counter ← 0; state ← BUSY.
- In BUSY:
  - Counter increments each cycle.
  - When counter = MEM_LAT-1, the owner's `rvalid` pulses for 1 cycle, and `rdata` = `mem_rdata` passed through combinationally.
  - The other requester's `rvalid` stays 0.
  - If no new grant occurs in this cycle, state ← IDLE.
- Throughput and latency:
  - One outstanding transaction; maximum one transaction per MEM_LAT cycles.
  - With MEM_LAT=1, the bus is back-to-back and fully utilised.
  - Latency from grant to `rvalid` is exactly MEM_LAT cycles.
- Stores:
  - `mem_we`=1, `mem_be`=`dm_be`.
  - Occupy the port for MEM_LAT cycles.
  - `dm_rvalid` pulses as a completion ack; `dm_rdata` is don't-care.
- `busy` = (state == BUSY).
- Boundary conditions:
  - Request dropped before grant: protocol violation; no checking required.
  - Simultaneous request and response cycle: the response goes to the old owner and the grant goes to the new requester in the same cycle. The two are independent.
  - rst asserted mid-transaction: the transaction is abandoned, no `rvalid` pulse, and the memory response is ignored. A request present in the first cycle with rst=0 is granted in that cycle.
  - rst asserted together with `req`: no grant.

Optional Feature:
- Macro: FAIR_ARB_EN.
- Defined: when both requests are present in a grant-eligible cycle, grant the requester that is not last_gnt (round-robin). With last_gnt reset to IF, DM wins the first tie.
- Undefined: fixed DM priority. IF can starve under continuous `dm_req`. last_gnt is still maintained but unused.

Test Plan:
- MEM_LAT=2, `if_req`=1, `if_addr`=0x0 at cycle T → `if_gnt`=1, `mem_en`=1, `mem_addr`=0x0, `mem_be`=0xF at T; `if_rvalid`=1 at T+2 with `if_rdata`=`mem_rdata`=0x00500093; `dm_rvalid`=0 throughout.
- MEM_LAT=2, `if_req` and `dm_req` (load 0x100) both at T → `dm_gnt` at T; `if_gnt` at T+2; `dm_rvalid` at T+2; `if_rvalid` at T+4.
- Store `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF, `dm_be`=0x3 at T → `mem_we`=1, `mem_be`=0x3, `mem_wdata`=0xDEADBEEF at T; `dm_rvalid` at T+MEM_LAT; `if_rvalid` never.
- rst=1 at T+1 after a load granted at T (MEM_LAT=2) → no `dm_rvalid` at T+2; all outputs 0; `if_req` held at the first cycle after rst release → granted that same cycle.
- MEM_LAT=1, `if_req` held 4 cycles with addresses 0x0, 0x4, 0x8, 0xC → `if_gnt` every cycle; `if_rvalid` every cycle from T+1 to T+4, in order.
- Both requests held continuously, MEM_LAT=1 → with FAIR_ARB_EN: grants D, I, D, I; without: D every cycle, `if_gnt` stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one unified memory between fetch (IF) and load/store (DM).
// Define FAIR_ARB_EN for round-robin tie-breaking; the default build gives DM fixed priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [DW-1:0]   o_if_rdata,
    input  logic            i_dm_req,
    input  logic            i_dm_we,
    input  logic [AW-1:0]   i_dm_addr,
    input  logic [DW-1:0]   i_dm_wdata,
    input  logic [DW/8-1:0] i_dm_be,
    output logic            o_dm_gnt,
    output logic            o_dm_rvalid,
    output logic [DW-1:0]   o_dm_rdata,
    output logic            o_mem_en,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_be,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic            o_busy
);
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);
    localparam logic          OWN_IF   = 1'b0;
    localparam logic          OWN_DM   = 1'b1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_owner, w_owner_next;
    logic          r_we, w_we_next;
    logic          r_last_gnt, w_last_next;

    logic w_resp_cnt, w_resp, w_elig, w_pick_dm, w_gnt_if, w_gnt_dm;

    assign w_resp_cnt = (r_state == StBusy) && (r_cnt == LAST_CNT);
    assign w_resp     = w_resp_cnt && !i_rst;
    assign w_elig     = !i_rst && ((r_state == StIdle) || w_resp_cnt);

`ifdef FAIR_ARB_EN
    assign w_pick_dm = i_dm_req && (!i_if_req || (r_last_gnt == OWN_IF));
`else
    // last_gnt is tracked but does not affect the decision; this reduces to i_dm_req.
    assign w_pick_dm = i_dm_req | (i_dm_req & r_last_gnt);
`endif

    assign w_gnt_dm = w_elig && w_pick_dm;
    assign w_gnt_if = w_elig && i_if_req && !w_pick_dm;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_owner_next = r_owner;
        w_we_next    = r_we;
        w_last_next  = r_last_gnt;
        o_if_gnt     = w_gnt_if;
        o_dm_gnt     = w_gnt_dm;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        o_if_rvalid  = w_resp && (r_owner == OWN_IF);
        o_dm_rvalid  = w_resp && (r_owner == OWN_DM);
        o_if_rdata   = '0;
        o_dm_rdata   = '0;
        o_busy       = (r_state == StBusy);

        if (w_gnt_dm) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dm_we;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
            o_mem_be    = i_dm_be;
        end else if (w_gnt_if) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_if_addr;
            o_mem_be    = '1;
        end

        if (o_if_rvalid) begin
            o_if_rdata = i_mem_rdata;
        end
        if (o_dm_rvalid && !r_we) begin
            o_dm_rdata = i_mem_rdata;
        end

        if (r_state == StBusy) begin
            if (w_resp_cnt) begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end

        // A grant in the response cycle overrides the return to idle.
        if (w_gnt_dm || w_gnt_if) begin
            w_state_next = StBusy;
            w_cnt_next   = '0;
            w_owner_next = w_gnt_dm ? OWN_DM : OWN_IF;
            w_we_next    = w_gnt_dm && i_dm_we;
            w_last_next  = w_gnt_dm ? OWN_DM : OWN_IF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_owner    <= OWN_DM;
            r_we       <= 1'b0;
            r_last_gnt <= OWN_IF;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_owner    <= w_owner_next;
            r_we       <= w_we_next;
            r_last_gnt <= w_last_next;
        end
    end

endmodule
